// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of the shared BlockRAM slave.
// Round-robin grant held until cyc drops, plus per-access ack watchdog.
module wb_bram_arbiter #(
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [3:0]       m0_sel,
    input  logic [31:0]      m0_dat_ms,
    output logic [31:0]      m0_dat_sm,
    output logic             m0_ack,
    output logic             m0_err,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [3:0]       m1_sel,
    input  logic [31:0]      m1_dat_ms,
    output logic [31:0]      m1_dat_sm,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [3:0]       s_sel,
    output logic [31:0]      s_dat_ms,
    input  logic [31:0]      s_dat_sm,
    input  logic             s_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } grant_e;

    // Counter must reach TIMEOUT-1; +2 keeps at least one bit when disabled.
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0] WD_MAX = TMAX[WD_W-1:0];
    localparam logic WD_EN = (TIMEOUT != 0);

    grant_e          grant_q;
    logic            last_q;
    logic [WD_W-1:0] wdog_q;
    logic [WD_W-1:0] wdog_d;
    logic            stb_raw;
    logic            wd_fire;
    logic            gnt0;
    logic            gnt1;

    assign gnt0 = (grant_q == G0);
    assign gnt1 = (grant_q == G1);

    // Route the granted master onto the slave port; IDLE drives all zero.
    always_comb begin
        s_cyc    = 1'b0;
        stb_raw  = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = 4'h0;
        s_dat_ms = 32'h0;
        unique case (grant_q)
            G0: begin
                s_cyc    = m0_cyc;
                stb_raw  = m0_cyc & m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_ms = m0_dat_ms;
            end
            G1: begin
                s_cyc    = m1_cyc;
                stb_raw  = m1_cyc & m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_ms = m1_dat_ms;
            end
            default: ;
        endcase
    end

    // An ack arriving on the last allowed cycle beats the timeout.
    assign wd_fire = WD_EN & (wdog_q == WD_MAX) & stb_raw & ~s_ack;
    assign s_stb   = stb_raw & ~wd_fire;

    assign m0_ack = s_ack & gnt0;
    assign m1_ack = s_ack & gnt1;
    assign m0_err = wd_fire & gnt0;
    assign m1_err = wd_fire & gnt1;

    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

    // Count cycles a strobe has waited; any gap, ack or fire restarts it.
    always_comb begin
        wdog_d = '0;
        if (s_stb && !s_ack) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Grant FSM: hold until cyc drops, hand over directly, alternate on ties.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            unique case (grant_q)
                IDLE: begin
                    if (m0_cyc && m1_cyc) begin
                        grant_q <= last_q ? G0 : G1;
                    end else if (m0_cyc) begin
                        grant_q <= G0;
                    end else if (m1_cyc) begin
                        grant_q <= G1;
                    end
                end
                G0: begin
                    if (!m0_cyc) begin
                        last_q  <= 1'b0;
                        grant_q <= m1_cyc ? G1 : IDLE;
                    end
                end
                G1: begin
                    if (!m1_cyc) begin
                        last_q  <= 1'b1;
                        grant_q <= m0_cyc ? G0 : IDLE;
                    end
                end
                default: grant_q <= IDLE;
            endcase
        end
    end

endmodule
